uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 121 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter through a txrdy/txack presentation handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FEEDER_OVF_EN.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nothing presented, txrdy low; wait for data with hold low
// SEND  | mem[rd_ptr] presented on txdata, txrdy high until txack
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   input  logic              hold,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic [7:0]        txdata,
   output logic              txrdy,
   input  logic              txack,
   output logic              ovf
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level_q;
   logic              push;
   logic              pop;
   logic              post_pop_nonzero;

   assign full   = (level_q == (ADDR_W+1)'(DEPTH));
   assign empty  = (level_q == '0);
   assign level  = level_q;
   assign txdata = mem[rd_ptr];
   assign txrdy  = (state == SEND);

   assign pop  = (state == SEND) && txack;
   // A pop at the same edge frees the slot the push lands in, so full only blocks a lone push.
   assign push = wr_en && (!full || pop);

   assign post_pop_nonzero = (level_q != (ADDR_W+1)'(1)) || push;

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
            2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!empty && !hold) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            // hold is only honoured at a byte boundary so a presentation is never withdrawn.
            if (pop) begin
               state_nxt = (post_pop_nonzero && !hold) ? SEND : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef UART_TX_FEEDER_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (wr_en && full && !txack) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus randomized traffic checked
// against a queue-based reference model and a txdata scoreboard.
module tb_uart_tx_feeder;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
`ifdef UART_TX_FEEDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic [7:0]        wr_data;
   logic              wr_en;
   logic              hold;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic [7:0]        txdata;
   logic              txrdy;
   logic              txack;
   logic              ovf;

   int passed = 0;
   int total  = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   bit         m_send  = 1'b0;
   bit         m_ovf   = 1'b0;
   bit         armed   = 1'b0;

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .hold    (hold),
      .full    (full),
      .empty   (empty),
      .level   (level),
      .txdata  (txdata),
      .txrdy   (txrdy),
      .txack   (txack),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   // Reference model: FIFO contents as a queue, presentation flag from the handshake rules.
   always @(posedge clk) begin
      int  cnt_pre;
      bit  full_pre;
      bit  do_pop;
      bit  do_push;
      if (reset) begin
         mq.delete();
         exp_q.delete();
         m_send = 1'b0;
         m_ovf  = 1'b0;
         armed  = 1'b1;
      end else begin
         cnt_pre  = mq.size();
         full_pre = (cnt_pre == DEPTH);
         do_pop   = m_send && txack;
         do_push  = wr_en && (!full_pre || do_pop);
         if (wr_en && full_pre && !txack) m_ovf = 1'b1;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(wr_data);
            exp_q.push_back(wr_data);
         end
         if (!m_send) m_send = (cnt_pre != 0) && !hold;
         else if (do_pop) m_send = (mq.size() != 0) && !hold;
      end
   end

   // Status checker against the model.
   always @(negedge clk) begin
      if (armed) begin
         chk("txrdy", 32'(txrdy), 32'(m_send));
         chk("level", 32'(level), 32'(mq.size()));
         chk("full",  32'(full),  32'(mq.size() == DEPTH));
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("ovf",   32'(ovf),   32'(OVF_EN && m_ovf));
      end
   end

   // Scoreboard monitor: every presented byte must be the oldest outstanding one.
   always @(negedge clk) begin
      if (armed && txrdy) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL txdata_sb actual=%0h required=<none queued> at %0t", txdata, $time);
         end else begin
            chk("txdata_sb", 32'(txdata), 32'(exp_q[0]));
            if (txack) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step(input logic r, input logic w, input logic [7:0] d,
                       input logic h, input logic a);
      reset   = r;
      wr_en   = w;
      wr_data = d;
      hold    = h;
      txack   = a;
      @(posedge clk);
      #1;
   endtask

   int pw;
   int pa;
   int ph;

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_data = '0; hold = 1'b0; txack = 1'b0;
      step(1, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);
      chk("rst_txrdy", 32'(txrdy), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full",  32'(full),  0);
      chk("rst_level", 32'(level), 0);
      chk("rst_ovf",   32'(ovf),   0);

      // single byte
      step(0, 1, 8'h41, 0, 0);
      chk("single_not_yet", 32'(txrdy), 0);
      step(0, 0, 8'h00, 0, 0);
      chk("single_txrdy", 32'(txrdy), 1);
      chk("single_data", 32'(txdata), 32'h41);
      step(0, 0, 8'h00, 0, 1);
      chk("single_drop", 32'(txrdy), 0);
      chk("single_empty", 32'(empty), 1);

      // three bytes, spaced acks
      step(0, 1, 8'h55, 0, 0);
      step(0, 1, 8'hAA, 0, 0);
      step(0, 1, 8'h0F, 0, 0);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 19; j++) step(0, 0, 8'h00, 0, 0);
         step(0, 0, 8'h00, 0, 1);
      end
      chk("three_done", 32'(txrdy), 0);

      // overflow: 17 writes, then drain in order
      for (int i = 0; i < 17; i++) step(0, 1, 8'(8'h80 + i), 0, 0);
      chk("fill_level", 32'(level), 16);
      chk("fill_full", 32'(full), 1);
      chk("fill_ovf", 32'(ovf), 32'(OVF_EN));
      for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1);
      chk("drain_empty", 32'(empty), 1);

      // push and pop while full
      step(1, 0, 8'h00, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h20 + i), 0, 0);
      step(0, 1, 8'hEE, 0, 1);
      chk("fullpp_level", 32'(level), 16);
      chk("fullpp_ovf", 32'(ovf), 0);
      chk("fullpp_txrdy", 32'(txrdy), 1);
      for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 0, 1);

      // hold behaviour
      step(1, 0, 8'h00, 0, 0);
      step(0, 1, 8'h11, 1, 0);
      step(0, 1, 8'h22, 1, 0);
      step(0, 0, 8'h00, 1, 0);
      chk("hold_idle", 32'(txrdy), 0);
      step(0, 0, 8'h00, 0, 0);
      chk("hold_release", 32'(txrdy), 1);
      step(0, 0, 8'h00, 1, 0);
      chk("hold_midsend", 32'(txrdy), 1);
      step(0, 0, 8'h00, 1, 1);
      chk("hold_ack_txrdy", 32'(txrdy), 0);
      chk("hold_ack_level", 32'(level), 1);
      step(0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 1);

      // reset during presentation
      for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
      step(0, 0, 8'h00, 0, 0);
      chk("rsend_txrdy_pre", 32'(txrdy), 1);
      step(1, 0, 8'h00, 0, 0);
      chk("rsend_txrdy", 32'(txrdy), 0);
      chk("rsend_level", 32'(level), 0);
      step(0, 0, 8'h00, 0, 1);
      chk("stray_txrdy", 32'(txrdy), 0);
      chk("stray_level", 32'(level), 0);

      // randomized traffic
      for (int blk = 0; blk < 15; blk++) begin
         pw = int'($urandom_range(1, 9));
         pa = int'($urandom_range(0, 9));
         ph = int'($urandom_range(0, 3));
         for (int c = 0; c < 200; c++) begin
            step($urandom_range(0, 299) == 0,
                 int'($urandom_range(0, 9)) < pw,
                 8'($urandom),
                 int'($urandom_range(0, 9)) < ph,
                 int'($urandom_range(0, 9)) < pa);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
